// File: rtl/timer_tick_master.sv
// rtl/timer_tick_master.sv - bus master that programs a timer, services its interrupts and snapshots its counter
module timer_tick_master #(
    parameter logic [15:0] CTRL_RUN  = 16'h0007,
    parameter logic [15:0] CTRL_STOP = 16'h0008
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic        snap_req,
    input  logic [31:0] period_in,
    output logic [2:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [15:0] m_writedata,
    input  logic [15:0] m_readdata,
    input  logic        irq,
    output logic        busy,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic [31:0] snapshot,
    output logic        snap_valid
);

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        RUN,
        CLR,
        SNAP_W,
        RD_L,
        CAP_L,
        RD_H,
        CAP_H,
        WR_STOP
    } state_t;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    state_t      state;
    logic [31:0] period;
    logic        stop_pend;
    logic        snap_pend;

    // Single FSM: every output is registered and set for the state being entered,
    // so the bus signals seen in a cycle always belong to the current state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            period       <= 32'h0;
            stop_pend    <= 1'b0;
            snap_pend    <= 1'b0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= 3'd0;
            m_writedata  <= 16'h0;
            busy         <= 1'b0;
            tick         <= 1'b0;
            tick_count   <= 16'h0;
            snapshot     <= 32'h0;
            snap_valid   <= 1'b0;
        end else begin
            // Bus idle and pulses low unless the entered state says otherwise.
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= 3'd0;
            m_writedata  <= 16'h0;
            tick         <= 1'b0;
            snap_valid   <= 1'b0;

            // Requests arriving mid-sequence are remembered until RUN can act on them.
            if (state != IDLE) begin
                if (stop)     stop_pend <= 1'b1;
                if (snap_req) snap_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start && (period_in != 32'h0)) begin
                        state        <= WR_PL;
                        period       <= period_in;
                        tick_count   <= 16'h0;
                        busy         <= 1'b1;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_address    <= ADDR_PERIOD_L;
                        m_writedata  <= period_in[15:0];
                    end
                end
                WR_PL: begin
                    state        <= WR_PH;
                    m_chipselect <= 1'b1;
                    m_write_n    <= 1'b0;
                    m_address    <= ADDR_PERIOD_H;
                    m_writedata  <= period[31:16];
                end
                WR_PH: begin
                    state        <= WR_CTRL;
                    m_chipselect <= 1'b1;
                    m_write_n    <= 1'b0;
                    m_address    <= ADDR_CONTROL;
                    m_writedata  <= CTRL_RUN;
                end
                WR_CTRL: begin
                    state <= RUN;
                end
                RUN: begin
                    if (stop_pend || stop) begin
                        // Stopping makes any outstanding snapshot meaningless.
                        state        <= WR_STOP;
                        stop_pend    <= 1'b0;
                        snap_pend    <= 1'b0;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_address    <= ADDR_CONTROL;
                        m_writedata  <= CTRL_STOP;
                    end else if (irq) begin
                        state        <= CLR;
                        tick         <= 1'b1;
                        tick_count   <= tick_count + 16'd1;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_address    <= ADDR_STATUS;
                    end else if (snap_pend || snap_req) begin
                        state        <= SNAP_W;
                        snap_pend    <= 1'b0;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_address    <= ADDR_SNAP_L;
                    end
                end
                CLR: begin
                    state <= RUN;
                end
                SNAP_W: begin
                    state        <= RD_L;
                    m_chipselect <= 1'b1;
                    m_address    <= ADDR_SNAP_L;
                end
                RD_L: begin
                    state        <= CAP_L;
                    m_chipselect <= 1'b1;
                    m_address    <= ADDR_SNAP_H;
                end
                CAP_L: begin
                    // Read data for the low half arrives while the high half is addressed.
                    state           <= CAP_H;
                    snapshot[15:0]  <= m_readdata;
                end
                CAP_H: begin
                    state           <= RUN;
                    snapshot[31:16] <= m_readdata;
                    snap_valid      <= 1'b1;
                end
                WR_STOP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    // RD_H is folded into CAP_L; recover to IDLE if it is ever seen.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_tick_master.sv
// tb/tb_timer_tick_master.sv - scoreboard bench for timer_tick_master
module tb_timer_tick_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic        snap_req;
    logic [31:0] period_in;
    logic [2:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [15:0] m_writedata;
    logic [15:0] m_readdata = 16'h0;
    logic        irq = 1'b0;
    logic        busy;
    logic        tick;
    logic [15:0] tick_count;
    logic [31:0] snapshot;
    logic        snap_valid;

    typedef struct packed {
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] data;
    } acc_t;

    acc_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          ticks_seen = 0;
    int          snaps_seen = 0;
    logic        sb_en;
    logic        irq_req;
    logic        irq_hold;
    logic [15:0] snap_l = 16'h0;
    logic [15:0] snap_h = 16'h0;
    logic [31:0] snap_exp = 32'h0;

    timer_tick_master dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .stop         (stop),
        .snap_req     (snap_req),
        .period_in    (period_in),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .irq          (irq),
        .busy         (busy),
        .tick         (tick),
        .tick_count   (tick_count),
        .snapshot     (snapshot),
        .snap_valid   (snap_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [2:0] addr, input logic [15:0] data);
        acc_t e;
        e.wr   = wr;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Timer slave: registered read data, irq raised by the bench, cleared by a status write.
    always @(posedge clk) begin
        if (m_chipselect && m_write_n)
            m_readdata <= (m_address == 3'd4) ? snap_l : (m_address == 3'd5) ? snap_h : 16'h0;
        if (irq_hold || irq_req)
            irq <= 1'b1;
        else if (m_chipselect && !m_write_n && m_address == 3'd0)
            irq <= 1'b0;
    end

    // Monitor: every bus access is matched against the head of the expected queue.
    always @(negedge clk) begin
        if (reset_n) begin
            if (m_chipselect && sb_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_access actual=%b/%0d/%h required=none",
                             ~m_write_n, m_address, m_writedata);
                end else begin
                    acc_t e;
                    e = exp_q.pop_front();
                    chk("bus_access", {12'h0, ~m_write_n, m_address, m_writedata}, {12'h0, e});
                end
            end
            if (tick) ticks_seen++;
            if (snap_valid) begin
                snaps_seen++;
                chk("snapshot_on_valid", snapshot, snap_exp);
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic raise_irq();
        irq_req = 1'b1;
        @(negedge clk);
        irq_req = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int s0;
        int cyc;
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; snap_req = 1'b0;
        period_in = 32'h0; irq_req = 1'b0; irq_hold = 1'b0; sb_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs", m_chipselect, 0);
        chk("rst_write_n", m_write_n, 1);
        chk("rst_addr", m_address, 0);
        chk("rst_wdata", m_writedata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick_count", tick_count, 0);
        chk("rst_snapshot", snapshot, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Zero period start is ignored.
        start = 1'b1; period_in = 32'h0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("zero_period_ignored", busy, 0);

        // Programming sequence.
        push(1, 3'd2, 16'h86A0); push(1, 3'd3, 16'h0001); push(1, 3'd1, 16'h0007);
        start = 1'b1; period_in = 32'h0001_86A0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        wait_drain();

        // Interrupt service.
        push(1, 3'd0, 16'h0000);
        t0 = ticks_seen;
        raise_irq();
        wait_drain();
        repeat (3) @(negedge clk);
        chk("tick_count_one", tick_count, 1);
        chk("single_tick", ticks_seen - t0, 1);

        // Counter snapshot.
        snap_l = 16'h1234; snap_h = 16'h0005; snap_exp = 32'h0005_1234;
        push(1, 3'd4, 16'h0); push(0, 3'd4, 16'h0); push(0, 3'd5, 16'h0);
        s0 = snaps_seen;
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        wait_drain();
        repeat (4) @(negedge clk);
        chk("snapshot_value", snapshot, 32'h0005_1234);
        chk("single_snap_valid", snaps_seen - s0, 1);

        // Stop from RUN; results hold.
        push(1, 3'd1, 16'h0008);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_drain();
        repeat (2) @(negedge clk);
        chk("idle_after_stop", busy, 0);
        chk("tick_count_hold", tick_count, 1);
        chk("snapshot_hold", snapshot, 32'h0005_1234);

        // Stop in IDLE is ignored.
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (4) @(negedge clk);
        chk("stop_in_idle", busy, 0);

        // Start and stop together: start wins, stop dropped.
        push(1, 3'd2, 16'h0010); push(1, 3'd3, 16'h0000); push(1, 3'd1, 16'h0007);
        start = 1'b1; stop = 1'b1; period_in = 32'h0000_0010;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        chk("start_beats_stop", busy, 1);
        chk("tick_count_cleared", tick_count, 0);

        // Tick counter wrap: 65535 back-to-back interrupts, then one more.
        sb_en = 1'b0;
        t0 = ticks_seen;
        cyc = 0;
        irq_hold = 1'b1;
        while ((ticks_seen - t0) < 65535 && cyc < 140000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        irq_hold = 1'b0;
        chk("bulk_ticks", ticks_seen - t0, 65535);
        repeat (4) @(negedge clk);
        chk("tick_count_ffff", tick_count, 16'hFFFF);
        sb_en = 1'b1;
        push(1, 3'd0, 16'h0000);
        t0 = ticks_seen;
        raise_irq();
        wait_drain();
        repeat (2) @(negedge clk);
        chk("tick_count_wrap", tick_count, 0);
        chk("wrap_tick", ticks_seen - t0, 1);

        push(1, 3'd1, 16'h0008);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_drain();
        repeat (2) @(negedge clk);
        chk("idle_after_stop2", busy, 0);

        // Stop and snap during WR_PH: stop runs after programming, snap discarded.
        push(1, 3'd2, 16'h0003); push(1, 3'd3, 16'h0002);
        push(1, 3'd1, 16'h0007); push(1, 3'd1, 16'h0008);
        s0 = snaps_seen;
        start = 1'b1; period_in = 32'h0002_0003;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        stop = 1'b1; snap_req = 1'b1;
        @(negedge clk);
        stop = 1'b0; snap_req = 1'b0;
        wait_drain();
        repeat (6) @(negedge clk);
        chk("idle_after_pending_stop", busy, 0);
        chk("snap_discarded", snaps_seen - s0, 0);

        // Reset during WR_PH abandons the sequence.
        push(1, 3'd2, 16'h0005); push(1, 3'd3, 16'h0000);
        start = 1'b1; period_in = 32'h0000_0005;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_cs", m_chipselect, 0);
        chk("midrst_write_n", m_write_n, 1);
        chk("midrst_addr", m_address, 0);
        chk("midrst_wdata", m_writedata, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_snapshot", snapshot, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_no_more_access", exp_q.size(), 0);
        chk("midrst_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_tick_master.md
TIMER_TICK_MASTER -- requirements
Module: timer_tick_master

Interface
REQ-001 SHALL have parameter CTRL_RUN, default 16'h0007, control word written at start (ITO | CONT | START).
REQ-002 SHALL have parameter CTRL_STOP, default 16'h0008, control word written at stop (STOP bit only).
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to program the timer and run it.
REQ-006 stop  in  1  one-cycle request to halt the timer.
REQ-007 snap_req  in  1  one-cycle request to capture and read the timer counter.
REQ-008 period_in  in  32  timer period, sampled on an accepted start.
REQ-009 m_address  out  3  timer register address: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
REQ-010 m_chipselect  out  1  bus access valid.
REQ-011 m_write_n  out  1  low for a write.
REQ-012 m_writedata  out  16  write data.
REQ-013 m_readdata  in  16  slave read data, registered, valid the cycle after the address was driven.
REQ-014 irq  in  1  timer interrupt, level, held until status is written.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 tick  out  1  one-cycle pulse per serviced interrupt.
REQ-017 tick_count  out  16  serviced interrupts since the last accepted start.
REQ-018 snapshot  out  32  last counter value read.
REQ-019 snap_valid  out  1  one-cycle pulse when snapshot updates.

Function
REQ-020 Each bus access SHALL last exactly one cycle; the slave inserts no wait states.
REQ-021 FSM states: IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR, SNAP_W, RD_L, CAP_L, RD_H, CAP_H, WR_STOP.
REQ-022 IDLE: bus idle (cs=0, write_n=1, addr=0, wdata=0); start with period_in!=0 -> WR_PL, latch period, clear tick_count; start with period_in==0 ignored.
REQ-023 WR_PL writes addr 2 with period[15:0]; WR_PH writes addr 3 with period[31:16]; WR_CTRL writes addr 1 with CTRL_RUN; each advances after one cycle; WR_CTRL -> RUN.
REQ-024 RUN priority: pending stop -> WR_STOP; else irq=1 -> CLR; else pending snap -> SNAP_W; else remain, bus idle.
REQ-025 CLR writes addr 0 with 0; tick=1 in this cycle; tick_count increments modulo 2^16 (16'hFFFF -> 0); -> RUN.
REQ-026 SNAP_W writes addr 4 (data 0); RD_L drives addr 4 read (cs=1, write_n=1); CAP_L captures m_readdata into snapshot[15:0] while driving addr 5 read; CAP_H captures m_readdata into snapshot[31:16], pulses snap_valid, -> RUN. RD_H is merged into CAP_L; state unused and SHALL be unreachable.
REQ-027 WR_STOP writes addr 1 with CTRL_STOP; -> IDLE; tick_count and snapshot hold.
REQ-028 stop and snap_req SHALL each set a pending flag when asserted in any busy state; the flag clears when its sequence begins; stop in IDLE ignored; snap_req in IDLE ignored.
REQ-029 start while busy SHALL be ignored.
REQ-030 A pending stop SHALL discard a pending snap.
REQ-031 A timer timeout coinciding with the CLR write is lost (slave clear wins); not an error.
REQ-032 Simultaneous start and stop in IDLE: start accepted, stop ignored.

Reset
REQ-033 On reset_n low, SHALL immediately enter IDLE: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, busy=0, tick=0, tick_count=0, snapshot=0, snap_valid=0, pending flags cleared.
REQ-034 Reset mid-sequence SHALL abandon the sequence with no further bus activity; the timer is not reprogrammed.

Verification
REQ-035 start, period_in=32'h0001_86A0 -> writes (2,16'h86A0), (3,16'h0001), (1,16'h0007) on consecutive cycles; busy=1 from the next cycle.
REQ-036 In RUN, irq high -> next cycle writes (0,16'h0000), tick=1, tick_count 0->1; irq held low -> no further writes.
REQ-037 snap_req in RUN, slave returns 16'h1234 then 16'h0005 -> snapshot=32'h0005_1234, snap_valid one cycle; access order (w4), (r4), (r5).
REQ-038 tick_count preloaded to 16'hFFFF via 65535 irqs, one more irq -> tick_count=0, tick=1.
REQ-039 stop and snap_req during WR_PH -> after WR_CTRL writes (1,16'h0008), IDLE, snap never issued.
REQ-040 reset_n low during WR_PH -> all outputs at reset values within the same cycle; no WR_CTRL write after release.
